// File: rtl/irq_ctrl.sv
// Interrupt request controller: synchronizes eight async sources, qualifies them
// as level or edge, latches edge events and presents enabled pending bits as irq.
module irq_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic [7:0]  src_in,
   input  logic        cs_n,
   input  logic        as_n,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_n,
   output logic [7:0]  irq
);

   localparam logic [1:0] ADDR_PEND = 2'd0;
   localparam logic [1:0] ADDR_MODE = 2'd1;
   localparam logic [1:0] ADDR_POL  = 2'd2;
   localparam logic [1:0] ADDR_EN   = 2'd3;

   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0] sync;
   logic [7:0] prev;
   logic [7:0] pend;
   logic [7:0] mode;
   logic [7:0] pol;
   logic [7:0] en;

   logic       access;
   logic       wr_pend;
   logic       wr_mode;
   logic       wr_pol;
   logic       wr_en;
   logic [7:0] hit;
   logic [7:0] w1c;
   logic [7:0] to_edge;
   logic [7:0] pend_nxt;
   logic [7:0] reg_rd;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= src_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   always_comb begin
      access  = !cs_n && !as_n;
      wr_pend = access && !rw && (addr == ADDR_PEND);
      wr_mode = access && !rw && (addr == ADDR_MODE);
      wr_pol  = access && !rw && (addr == ADDR_POL);
      wr_en   = access && !rw && (addr == ADDR_EN);
      hit     = (pol & sync & ~prev) | (~pol & ~sync & prev);
      w1c     = wr_pend ? wr_data[7:0] : 8'h00;
      to_edge = wr_mode ? (wr_data[7:0] & ~mode) : 8'h00;
      // edge bits: a new hit beats a same-cycle W1C; level bits track the line
      pend_nxt = ((mode & (hit | (pend & ~w1c))) | (~mode & ~(sync ^ pol))) & ~to_edge;
   end

   always_comb begin
      reg_rd = 8'h00;
      case (addr)
         ADDR_PEND: reg_rd = pend;
         ADDR_MODE: reg_rd = mode;
         ADDR_POL:  reg_rd = pol;
         ADDR_EN:   reg_rd = en;
         default:   reg_rd = 8'h00;
      endcase
   end

   // prev always follows sync, which also covers the reload on config writes
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         prev    <= 8'h00;
         pend    <= 8'h00;
         mode    <= 8'h00;
         pol     <= 8'hFF;
         en      <= 8'h00;
         irq     <= 8'h00;
         rdy_n   <= 1'b1;
         rd_data <= 32'h0;
      end else begin
         prev <= sync;
         pend <= pend_nxt;
         irq  <= pend & en;
         if (wr_mode) mode <= wr_data[7:0];
         if (wr_pol)  pol  <= wr_data[7:0];
         if (wr_en)   en   <= wr_data[7:0];
         rdy_n   <= !access;
         rd_data <= (access && rw) ? {24'h0, reg_rd} : 32'h0;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a history-based model.
module tb_irq_ctrl;

   localparam int N = 2;

   logic        cpu_clk;
   logic        cpu_rstn;
   logic [7:0]  src_in;
   logic        cs_n;
   logic        as_n;
   logic        rw;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rdy_n;
   logic [7:0]  irq;

   int n_total = 0;
   int n_pass  = 0;
   logic cmp_en = 1'b0;

   irq_ctrl #(.SYNC_STAGES(N)) dut (
      .cpu_clk (cpu_clk),
      .cpu_rstn(cpu_rstn),
      .src_in  (src_in),
      .cs_n    (cs_n),
      .as_n    (as_n),
      .rw      (rw),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .rdy_n   (rdy_n),
      .irq     (irq)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: smp[k] is src_in as sampled k+1 edges ago, so sync and prev are
   // simply older entries of the sample history.
   logic [7:0]  smp [0:3];
   logic [7:0]  m_mode, m_pol, m_en, m_pend, m_irq;
   logic        m_rdy_n;
   logic [31:0] m_rd;

   function automatic logic [7:0] f_reg(input logic [1:0] a);
      case (a)
         2'd0:    return m_pend;
         2'd1:    return m_mode;
         2'd2:    return m_pol;
         default: return m_en;
      endcase
   endfunction

   function automatic logic [7:0] f_pend();
      logic [7:0] r;
      logic       wr_a;
      logic       sy, pv;
      r    = 8'h00;
      wr_a = !cs_n && !as_n && !rw;
      for (int i = 0; i < 8; i++) begin
         sy = smp[N-1][i];
         pv = smp[N][i];
         if (wr_a && addr == 2'd1 && wr_data[i] && !m_mode[i]) r[i] = 1'b0;
         else if (m_mode[i]) begin
            if (m_pol[i] ? (sy && !pv) : (!sy && pv)) r[i] = 1'b1;
            else if (wr_a && addr == 2'd0 && wr_data[i]) r[i] = 1'b0;
            else r[i] = m_pend[i];
         end else r[i] = (sy == m_pol[i]);
      end
      return r;
   endfunction

   always @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         for (int k = 0; k < 4; k++) smp[k] <= 8'h00;
         m_mode  <= 8'h00;
         m_pol   <= 8'hFF;
         m_en    <= 8'h00;
         m_pend  <= 8'h00;
         m_irq   <= 8'h00;
         m_rdy_n <= 1'b1;
         m_rd    <= 32'h0;
      end else begin
         m_pend  <= f_pend();
         m_irq   <= m_pend & m_en;
         m_rdy_n <= !(!cs_n && !as_n);
         m_rd    <= (!cs_n && !as_n && rw) ? {24'h0, f_reg(addr)} : 32'h0;
         if (!cs_n && !as_n && !rw) begin
            case (addr)
               2'd1:    m_mode <= wr_data[7:0];
               2'd2:    m_pol  <= wr_data[7:0];
               2'd3:    m_en   <= wr_data[7:0];
               default: ;
            endcase
         end
         smp[0] <= src_in;
         for (int k = 1; k < 4; k++) smp[k] <= smp[k-1];
      end
   end

   always @(negedge cpu_clk) begin
      if (cmp_en) begin
         chk("model_irq", {24'h0, irq}, {24'h0, m_irq});
         chk("model_rdy_n", {31'h0, rdy_n}, {31'h0, m_rdy_n});
         chk("model_rd_data", rd_data, m_rd);
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge cpu_clk);
      cs_n = 1'b0; as_n = 1'b0; rw = 1'b0; addr = a; wr_data = d;
      @(posedge cpu_clk);
      #1;
      cs_n = 1'b1; as_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
      @(negedge cpu_clk);
      cs_n = 1'b0; as_n = 1'b0; rw = 1'b1; addr = a;
      @(posedge cpu_clk);
      #1;
      cs_n = 1'b1; as_n = 1'b1;
      @(negedge cpu_clk);
      chk({name, "_ack"}, {31'h0, rdy_n}, 32'h0);
      chk(name, rd_data, {24'h0, exp});
      @(negedge cpu_clk);
      chk({name, "_ack_end"}, {31'h0, rdy_n}, 32'h1);
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   initial begin
      cs_n = 1'b1; as_n = 1'b1; rw = 1'b0; addr = 2'd0; wr_data = 32'h0;
      src_in = 8'h00; cpu_rstn = 1'b0;
      repeat (3) @(posedge cpu_clk);
      #1;
      chk("reset_irq", {24'h0, irq}, 32'h0);
      chk("reset_rdy_n", {31'h0, rdy_n}, 32'h1);
      chk("reset_rd_data", rd_data, 32'h0);
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      cmp_en   = 1'b1;

      rd(2'd0, 8'h00, "rst_pend");
      rd(2'd1, 8'h00, "rst_mode");
      rd(2'd2, 8'hFF, "rst_pol");
      rd(2'd3, 8'h00, "rst_en");

      // edge source 0, 2-cycle rising pulse
      wr(2'd1, 32'h01);
      wr(2'd3, 32'h01);
      @(negedge cpu_clk); src_in[0] = 1'b1;
      @(posedge cpu_clk);
      @(posedge cpu_clk);
      @(negedge cpu_clk); src_in[0] = 1'b0;
      edges(1);
      chk("edge0_before_e3", {31'h0, irq[0]}, 32'h0);
      edges(1);
      chk("edge0_at_e3", {31'h0, irq[0]}, 32'h1);
      edges(5);
      chk("edge0_held", {31'h0, irq[0]}, 32'h1);
      wr(2'd0, 32'h01);
      chk("w1c0_at_w", {31'h0, irq[0]}, 32'h1);
      edges(1);
      chk("w1c0_at_w1", {31'h0, irq[0]}, 32'h0);

      // level source 3, active-low
      wr(2'd2, 32'hF7);
      wr(2'd3, 32'h09);
      edges(3);
      chk("lvl3_active", {31'h0, irq[3]}, 32'h1);
      wr(2'd0, 32'h08);
      edges(3);
      chk("lvl3_w1c_ignored", {31'h0, irq[3]}, 32'h1);
      @(negedge cpu_clk); src_in[3] = 1'b1;
      edges(3);
      chk("lvl3_before_e3", {31'h0, irq[3]}, 32'h1);
      edges(1);
      chk("lvl3_at_e3", {31'h0, irq[3]}, 32'h0);

      // edge on source 5 in the same cycle as its W1C
      wr(2'd1, 32'h21);
      @(negedge cpu_clk); src_in[5] = 1'b1;
      @(posedge cpu_clk);
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      cs_n = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 2'd0; wr_data = 32'h20;
      @(posedge cpu_clk);
      #1;
      cs_n = 1'b1; as_n = 1'b1;
      rd(2'd0, 8'h20, "set_beats_w1c");

      // source 2 held high across a switch to rising-edge mode
      @(negedge cpu_clk); src_in[2] = 1'b1;
      edges(5);
      wr(2'd1, 32'h25);
      wr(2'd2, 32'hF7);
      edges(3);
      rd(2'd0, 8'h20, "mode_switch_no_edge");
      @(negedge cpu_clk); src_in[2] = 1'b0;
      edges(4);
      @(negedge cpu_clk); src_in[2] = 1'b1;
      edges(5);
      rd(2'd0, 8'h24, "src2_rise_after_fall");

      // disabled source still latches; enabling forwards it
      wr(2'd3, 32'h00);
      wr(2'd0, 32'hFF);
      rd(2'd0, 8'h00, "w1c_all");
      @(negedge cpu_clk); src_in[0] = 1'b1;
      edges(5);
      rd(2'd0, 8'h01, "disabled_pend");
      chk("disabled_irq", {24'h0, irq}, 32'h0);
      wr(2'd3, 32'hFF);
      chk("enable_at_w", {24'h0, irq}, 32'h0);
      edges(1);
      chk("enable_at_w1", {24'h0, irq}, 32'h01);

      // reset during the ack cycle of a read
      @(negedge cpu_clk);
      cs_n = 1'b0; as_n = 1'b0; rw = 1'b1; addr = 2'd2;
      @(posedge cpu_clk);
      #1;
      cs_n = 1'b1; as_n = 1'b1;
      chk("midread_ack", {31'h0, rdy_n}, 32'h0);
      #1 cpu_rstn = 1'b0;
      #1;
      chk("midread_rst_rdy_n", {31'h0, rdy_n}, 32'h1);
      chk("midread_rst_irq", {24'h0, irq}, 32'h0);
      chk("midread_rst_rd_data", rd_data, 32'h0);
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge cpu_clk);
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 9) == 0) src_in[b] = ~src_in[b];
         end
         if ($urandom_range(0, 99) < 45) begin
            cs_n    = ($urandom_range(0, 7) == 0);
            as_n    = 1'b0;
            rw      = $urandom_range(0, 1) == 1;
            addr    = 2'($urandom_range(0, 3));
            wr_data = $urandom;
         end else begin
            cs_n = ($urandom_range(0, 1) == 1);
            as_n = 1'b1;
         end
      end
      @(negedge cpu_clk);
      cs_n = 1'b1; as_n = 1'b1;
      repeat (4) @(negedge cpu_clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
